fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port CLK  input  1  rising-edge system clock.
REQ-002 SHALL have port RST_F  input  1  reset, asynchronous, active-low; clock CLK.
REQ-003 SHALL have port PC_RST  input  1  synchronous PC/IR clear strobe from controller.
REQ-004 SHALL have port PC_WRITE  input  1  fetch strobe: load IR, advance PC.
REQ-005 SHALL have port BR_SEL  input  1  execute-phase strobe: resolve branch in IR.
REQ-006 SHALL have port PC_SEL  input  1  apply pending branch redirect.
REQ-007 SHALL have port STAT  input  4  ALU status flags for bne.
REQ-008 SHALL have port IMEM_RDATA  input  32  instruction word, combinational read of IMEM_ADDR.
REQ-009 SHALL have port IMEM_ADDR  output  16  instruction memory word address.
REQ-010 SHALL have port INSTR  output  32  instruction register (IR) contents.
REQ-011 SHALL have port OPCODE  output  4  IR[31:28].
REQ-012 SHALL have port MM  output  4  IR[27:24].
REQ-013 SHALL have port PC  output  16  next sequential fetch address.
REQ-014 SHALL have port FPC  output  16  address the current IR was fetched from.
REQ-015 SHALL have port BR_PEND  output  1  taken branch resolved, redirect not yet applied.

Function
REQ-016 SHALL decode IR as OPCODE=[31:28], MM=[27:24], IMM=[15:0]; opcodes bra=4, brr=5, bne=6.
REQ-017 SHALL drive IMEM_ADDR = TGT when PC_SEL=1 and BR_PEND=1, else PC (combinational).
REQ-018 SHALL, on posedge with PC_WRITE=1: IR<=IMEM_RDATA, FPC<=IMEM_ADDR, PC<=IMEM_ADDR+1, BR_PEND<=0.
REQ-019 SHALL wrap PC modulo 2^16 (0xFFFF+1 -> 0x0000); all address arithmetic 16-bit, carry discarded.
REQ-020 SHALL, on posedge with BR_SEL=1 and PC_WRITE=0, resolve branch: bra TGT<=IMM; brr TGT<=FPC+IMM; bne TGT<=FPC+IMM.
REQ-021 SHALL set BR_PEND<=1 for bra and brr unconditionally, for bne only when (STAT & MM)==4'b0000; otherwise BR_PEND<=0.
REQ-022 SHALL treat BR_SEL=1 with non-branch OPCODE as BR_PEND<=0, TGT unchanged.
REQ-023 SHALL, on posedge with PC_SEL=1, PC_WRITE=0, BR_PEND=1: PC<=TGT, BR_PEND<=0 (IR, FPC unchanged).
REQ-024 SHALL leave PC unchanged when PC_SEL=1 and BR_PEND=0.
REQ-025 SHALL, if PC_WRITE=1 and a redirect is pending with PC_SEL=1, fetch from TGT (REQ-017/018 combined, redirect wins).
REQ-026 SHALL give priority PC_RST > PC_WRITE > BR_SEL > PC_SEL when asserted in the same cycle.
REQ-027 SHALL hold all registers when no strobe is asserted.
REQ-028 SHALL have one-cycle latency: OPCODE/MM reflect new instruction immediately after the PC_WRITE edge.

Reset
REQ-029 SHALL, while RST_F=0, asynchronously force PC=0x0000, FPC=0x0000, IR=0x00000000 (OPCODE noop), TGT=0x0000, BR_PEND=0.
REQ-030 SHALL, on posedge with PC_RST=1, synchronously apply the same values as REQ-029.
REQ-031 SHALL abandon any pending redirect on reset asserted mid-instruction; first fetch after release reads address 0x0000.

Verification
REQ-032 Reset then PC_WRITE pulse with IMEM[0]=0x81000003 -> INSTR=0x81000003, OPCODE=8, MM=1, FPC=0x0000, PC=0x0001.
REQ-033 IR=bra IMM=0x0040 at FPC=0x0005; BR_SEL then PC_SEL pulses -> BR_PEND 1 then 0, PC=0x0040; next fetch FPC=0x0040.
REQ-034 IR=brr IMM=0xFFFE at FPC=0x0010 -> TGT=0x000E; brr IMM=0x0002 at FPC=0xFFFF -> TGT=0x0001 (wrap).
REQ-035 IR=bne MM=0x4: STAT=0x2 -> BR_PEND=1, redirect taken; STAT=0x4 -> BR_PEND=0, PC_SEL leaves PC=FPC+1.
REQ-036 BR_PEND=1, PC_SEL and PC_WRITE both high same edge, TGT=0x0020 -> IMEM_ADDR=0x0020, FPC=0x0020, PC=0x0021, BR_PEND=0.
REQ-037 RST_F low for 3 ns between posedges while BR_PEND=1, PC=0x0033 -> outputs clear immediately without clock edge; next fetch from 0x0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC/IR registers, branch target resolution and redirect.
// The instruction memory is read combinationally at IMEM_ADDR.
module fetch_unit (
  input  logic        CLK,
  input  logic        RST_F,
  input  logic        PC_RST,
  input  logic        PC_WRITE,
  input  logic        BR_SEL,
  input  logic        PC_SEL,
  input  logic [3:0]  STAT,
  input  logic [31:0] IMEM_RDATA,
  output logic [15:0] IMEM_ADDR,
  output logic [31:0] INSTR,
  output logic [3:0]  OPCODE,
  output logic [3:0]  MM,
  output logic [15:0] PC,
  output logic [15:0] FPC,
  output logic        BR_PEND
);

  localparam logic [3:0] OpBra = 4'd4;
  localparam logic [3:0] OpBrr = 4'd5;
  localparam logic [3:0] OpBne = 4'd6;

  logic [31:0] ir_q, ir_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] fpc_q, fpc_d;
  logic [15:0] tgt_q, tgt_d;
  logic        br_pend_q, br_pend_d;

  logic        redirect;
  logic [15:0] fetch_addr;
  logic [3:0]  ir_opcode;
  logic [3:0]  ir_mm;
  logic [15:0] ir_imm;
  logic [15:0] rel_tgt;

  assign ir_opcode = ir_q[31:28];
  assign ir_mm     = ir_q[27:24];
  assign ir_imm    = ir_q[15:0];
  assign rel_tgt   = fpc_q + ir_imm;

  // A pending redirect steers the fetch address the moment PC_SEL rises.
  assign redirect   = PC_SEL && br_pend_q;
  assign fetch_addr = redirect ? tgt_q : pc_q;

  always_comb begin
    ir_d      = ir_q;
    pc_d      = pc_q;
    fpc_d     = fpc_q;
    tgt_d     = tgt_q;
    br_pend_d = br_pend_q;
    if (PC_RST) begin
      ir_d      = 32'h0000_0000;
      pc_d      = 16'h0000;
      fpc_d     = 16'h0000;
      tgt_d     = 16'h0000;
      br_pend_d = 1'b0;
    end else if (PC_WRITE) begin
      ir_d      = IMEM_RDATA;
      fpc_d     = fetch_addr;
      pc_d      = fetch_addr + 16'd1;
      br_pend_d = 1'b0;
    end else if (BR_SEL) begin
      case (ir_opcode)
        OpBra: begin
          tgt_d     = ir_imm;
          br_pend_d = 1'b1;
        end
        OpBrr: begin
          tgt_d     = rel_tgt;
          br_pend_d = 1'b1;
        end
        OpBne: begin
          tgt_d     = rel_tgt;
          br_pend_d = ((STAT & ir_mm) == 4'b0000);
        end
        default: br_pend_d = 1'b0;
      endcase
    end else if (redirect) begin
      pc_d      = tgt_q;
      br_pend_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      ir_q      <= 32'h0000_0000;
      pc_q      <= 16'h0000;
      fpc_q     <= 16'h0000;
      tgt_q     <= 16'h0000;
      br_pend_q <= 1'b0;
    end else begin
      ir_q      <= ir_d;
      pc_q      <= pc_d;
      fpc_q     <= fpc_d;
      tgt_q     <= tgt_d;
      br_pend_q <= br_pend_d;
    end
  end

  assign IMEM_ADDR = fetch_addr;
  assign INSTR     = ir_q;
  assign OPCODE    = ir_opcode;
  assign MM        = ir_mm;
  assign PC        = pc_q;
  assign FPC       = fpc_q;
  assign BR_PEND   = br_pend_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, reset corner cases, then
// randomized strobes checked against a behavioural model.
module tb_fetch_unit;

  logic        CLK;
  logic        RST_F;
  logic        PC_RST;
  logic        PC_WRITE;
  logic        BR_SEL;
  logic        PC_SEL;
  logic [3:0]  STAT;
  logic [31:0] IMEM_RDATA;
  logic [15:0] IMEM_ADDR;
  logic [31:0] INSTR;
  logic [3:0]  OPCODE;
  logic [3:0]  MM;
  logic [15:0] PC;
  logic [15:0] FPC;
  logic        BR_PEND;

  logic [31:0] imem [0:65535];
  assign IMEM_RDATA = imem[IMEM_ADDR];

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .CLK        (CLK),
    .RST_F      (RST_F),
    .PC_RST     (PC_RST),
    .PC_WRITE   (PC_WRITE),
    .BR_SEL     (BR_SEL),
    .PC_SEL     (PC_SEL),
    .STAT       (STAT),
    .IMEM_RDATA (IMEM_RDATA),
    .IMEM_ADDR  (IMEM_ADDR),
    .INSTR      (INSTR),
    .OPCODE     (OPCODE),
    .MM         (MM),
    .PC         (PC),
    .FPC        (FPC),
    .BR_PEND    (BR_PEND)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        wr;
    logic        bs;
    logic        ps;
    logic [3:0]  stat;
    logic [15:0] addr;
    logic [31:0] ir;
    logic [15:0] pc;
    logic [15:0] fpc;
    logic        pend;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic w, input logic b, input logic p,
                     input logic [3:0] s, input logic [15:0] a, input logic [31:0] ir,
                     input logic [15:0] pc, input logic [15:0] fpc, input logic pend);
    vec_t v;
    v.rst = r; v.wr = w; v.bs = b; v.ps = p; v.stat = s; v.addr = a;
    v.ir = ir; v.pc = pc; v.fpc = fpc; v.pend = pend;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic w, input logic b, input logic p,
                       input logic [3:0] s);
    @(negedge CLK);
    PC_RST = r; PC_WRITE = w; BR_SEL = b; PC_SEL = p; STAT = s;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] ir, input logic [15:0] pc,
                           input logic [15:0] fpc, input logic pend);
    logic [31:0] e;
    e = ir;
    chk({tag, " INSTR"}, INSTR, e);
    chk({tag, " OPCODE"}, {28'd0, OPCODE}, {28'd0, e[31:28]});
    chk({tag, " MM"}, {28'd0, MM}, {28'd0, e[27:24]});
    chk({tag, " PC"}, {16'd0, PC}, {16'd0, pc});
    chk({tag, " FPC"}, {16'd0, FPC}, {16'd0, fpc});
    chk({tag, " BR_PEND"}, {31'd0, BR_PEND}, {31'd0, pend});
  endtask

  // Behavioural reference: architectural state updated once per clock edge.
  logic [31:0] m_ir;
  logic [15:0] m_pc, m_fpc, m_tgt;
  logic        m_pend;

  function automatic logic [15:0] m_addr(input logic ps);
    if (ps && m_pend) return m_tgt;
    return m_pc;
  endfunction

  task automatic model_edge(input logic r, input logic w, input logic b, input logic p,
                            input logic [3:0] s);
    int unsigned op, mm, imm, a;
    op  = m_ir >> 28;
    mm  = (m_ir >> 24) & 15;
    imm = m_ir & 16'hFFFF;
    if (r) begin
      m_ir = 0; m_pc = 0; m_fpc = 0; m_tgt = 0; m_pend = 0;
    end else if (w) begin
      a      = m_addr(p);
      m_ir   = imem[a];
      m_fpc  = 16'(a);
      m_pc   = 16'((a + 1) % 65536);
      m_pend = 0;
    end else if (b) begin
      if (op == 4) begin
        m_tgt = 16'(imm); m_pend = 1;
      end else if (op == 5 || op == 6) begin
        m_tgt  = 16'((m_fpc + imm) % 65536);
        m_pend = (op == 5) ? 1'b1 : ((s & mm) == 0);
      end else begin
        m_pend = 0;
      end
    end else if (p && m_pend) begin
      m_pc = m_tgt; m_pend = 0;
    end
  endtask

  initial begin
    int unsigned op;
    RST_F = 1'b0; PC_RST = 0; PC_WRITE = 0; BR_SEL = 0; PC_SEL = 0; STAT = 0;

    // Random program image biased toward branch opcodes.
    for (int i = 0; i < 65536; i++) begin
      op = $urandom_range(0, 7);
      if (op > 6) op = $urandom_range(7, 15);
      else if (op < 3) op = op + 4;
      imem[i] = {op[3:0], 4'($urandom_range(0, 15)), 8'($urandom), 16'($urandom)};
    end
    imem[16'h0000] = 32'h8100_0003;
    imem[16'h0001] = 32'h4000_0005;
    imem[16'h0002] = 32'h6400_0030;
    imem[16'h0005] = 32'h4000_0040;
    imem[16'h000E] = 32'h4000_FFFF;
    imem[16'h0010] = 32'h5000_FFFE;
    imem[16'h0020] = 32'h1234_5678;
    imem[16'h0021] = 32'h4000_0070;
    imem[16'h0032] = 32'h6400_0010;
    imem[16'h0033] = 32'h4000_0020;
    imem[16'h0040] = 32'h4000_0010;
    imem[16'hFFFF] = 32'h5000_0002;

    //   rst wr bs ps stat addr      ir            pc        fpc       pend
    add(0, 1, 0, 0, 4'h0, 16'h0000, 32'h8100_0003, 16'h0001, 16'h0000, 0);
    add(0, 1, 0, 0, 4'h0, 16'h0001, 32'h4000_0005, 16'h0002, 16'h0001, 0);
    add(0, 0, 1, 0, 4'h0, 16'h0002, 32'h4000_0005, 16'h0002, 16'h0001, 1);
    add(0, 0, 0, 1, 4'h0, 16'h0005, 32'h4000_0005, 16'h0005, 16'h0001, 0);
    add(0, 1, 0, 0, 4'h0, 16'h0005, 32'h4000_0040, 16'h0006, 16'h0005, 0);
    add(0, 0, 1, 0, 4'h0, 16'h0006, 32'h4000_0040, 16'h0006, 16'h0005, 1);
    add(0, 0, 0, 1, 4'h0, 16'h0040, 32'h4000_0040, 16'h0040, 16'h0005, 0);
    add(0, 1, 0, 0, 4'h0, 16'h0040, 32'h4000_0010, 16'h0041, 16'h0040, 0);
    add(0, 0, 1, 0, 4'h0, 16'h0041, 32'h4000_0010, 16'h0041, 16'h0040, 1);
    add(0, 0, 0, 1, 4'h0, 16'h0010, 32'h4000_0010, 16'h0010, 16'h0040, 0);
    add(0, 1, 0, 0, 4'h0, 16'h0010, 32'h5000_FFFE, 16'h0011, 16'h0010, 0);
    add(0, 0, 1, 0, 4'h0, 16'h0011, 32'h5000_FFFE, 16'h0011, 16'h0010, 1);
    add(0, 0, 0, 1, 4'h0, 16'h000E, 32'h5000_FFFE, 16'h000E, 16'h0010, 0);
    add(0, 1, 0, 0, 4'h0, 16'h000E, 32'h4000_FFFF, 16'h000F, 16'h000E, 0);
    add(0, 0, 1, 0, 4'h0, 16'h000F, 32'h4000_FFFF, 16'h000F, 16'h000E, 1);
    add(0, 0, 0, 1, 4'h0, 16'hFFFF, 32'h4000_FFFF, 16'hFFFF, 16'h000E, 0);
    add(0, 1, 0, 0, 4'h0, 16'hFFFF, 32'h5000_0002, 16'h0000, 16'hFFFF, 0);
    add(0, 0, 1, 0, 4'h0, 16'h0000, 32'h5000_0002, 16'h0000, 16'hFFFF, 1);
    add(0, 0, 0, 1, 4'h0, 16'h0001, 32'h5000_0002, 16'h0001, 16'hFFFF, 0);
    add(0, 1, 0, 0, 4'h0, 16'h0001, 32'h4000_0005, 16'h0002, 16'h0001, 0);
    add(0, 1, 0, 0, 4'h0, 16'h0002, 32'h6400_0030, 16'h0003, 16'h0002, 0);
    add(0, 0, 1, 0, 4'h2, 16'h0003, 32'h6400_0030, 16'h0003, 16'h0002, 1);
    add(0, 0, 0, 1, 4'h0, 16'h0032, 32'h6400_0030, 16'h0032, 16'h0002, 0);
    add(0, 1, 0, 0, 4'h0, 16'h0032, 32'h6400_0010, 16'h0033, 16'h0032, 0);
    add(0, 0, 1, 0, 4'h4, 16'h0033, 32'h6400_0010, 16'h0033, 16'h0032, 0);
    add(0, 0, 0, 1, 4'h0, 16'h0033, 32'h6400_0010, 16'h0033, 16'h0032, 0);
    add(0, 1, 0, 0, 4'h0, 16'h0033, 32'h4000_0020, 16'h0034, 16'h0033, 0);
    add(0, 0, 1, 0, 4'h0, 16'h0034, 32'h4000_0020, 16'h0034, 16'h0033, 1);
    add(0, 1, 0, 1, 4'h0, 16'h0020, 32'h1234_5678, 16'h0021, 16'h0020, 0);
    add(0, 1, 1, 0, 4'h0, 16'h0021, 32'h4000_0070, 16'h0022, 16'h0021, 0);
    add(0, 0, 1, 0, 4'h0, 16'h0022, 32'h4000_0070, 16'h0022, 16'h0021, 1);
    add(0, 0, 1, 1, 4'h0, 16'h0070, 32'h4000_0070, 16'h0022, 16'h0021, 1);
    add(1, 1, 0, 0, 4'h0, 16'h0022, 32'h0000_0000, 16'h0000, 16'h0000, 0);
    add(0, 1, 0, 0, 4'h0, 16'h0000, 32'h8100_0003, 16'h0001, 16'h0000, 0);
    add(0, 0, 1, 0, 4'h0, 16'h0001, 32'h8100_0003, 16'h0001, 16'h0000, 0);
    add(0, 0, 0, 1, 4'h0, 16'h0001, 32'h8100_0003, 16'h0001, 16'h0000, 0);
    add(0, 0, 0, 0, 4'h0, 16'h0001, 32'h8100_0003, 16'h0001, 16'h0000, 0);

    #3;
    chk_state("reset", 32'h0, 16'h0, 16'h0, 1'b0);
    #9 RST_F = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].wr, vecs[i].bs, vecs[i].ps, vecs[i].stat);
      #1;
      chk($sformatf("vec%0d IMEM_ADDR", i), {16'd0, IMEM_ADDR}, {16'd0, vecs[i].addr});
      tick();
      chk_state($sformatf("vec%0d", i), vecs[i].ir, vecs[i].pc, vecs[i].fpc, vecs[i].pend);
    end

    // Async reset mid-cycle with a redirect pending at PC=0x0033.
    imem[16'h0000] = 32'h4000_0032;
    drive(1, 0, 0, 0, 4'h0); tick();
    drive(0, 1, 0, 0, 4'h0); tick();
    drive(0, 0, 1, 0, 4'h0); tick();
    drive(0, 0, 0, 1, 4'h0); tick();
    drive(0, 1, 0, 0, 4'h0); tick();
    drive(0, 0, 1, 0, 4'h0); tick();
    chk_state("pre_async", 32'h6400_0010, 16'h0033, 16'h0032, 1'b1);
    drive(0, 0, 0, 0, 4'h0);
    @(posedge CLK);
    #2 RST_F = 1'b0;
    #1 chk_state("async", 32'h0, 16'h0, 16'h0, 1'b0);
    chk("async IMEM_ADDR", {16'd0, IMEM_ADDR}, 32'h0);
    #2 RST_F = 1'b1;
    drive(0, 1, 0, 0, 4'h0); tick();
    chk_state("post_async", 32'h4000_0032, 16'h0001, 16'h0000, 1'b0);

    // Randomized strobes against the reference model.
    drive(1, 0, 0, 0, 4'h0); tick();
    model_edge(1, 0, 0, 0, 4'h0);
    for (int n = 0; n < 3000; n++) begin
      logic r, w, b, p;
      logic [3:0] s;
      r = ($urandom_range(0, 99) == 0);
      w = ($urandom_range(0, 99) < 30);
      b = ($urandom_range(0, 99) < 35);
      p = ($urandom_range(0, 99) < 40);
      s = 4'($urandom);
      drive(r, w, b, p, s);
      #1 chk($sformatf("rnd%0d IMEM_ADDR", n), {16'd0, IMEM_ADDR}, {16'd0, m_addr(p)});
      tick();
      model_edge(r, w, b, p, s);
      chk_state($sformatf("rnd%0d", n), m_ir, m_pc, m_fpc, m_pend);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
